regfile_write_arbiter: RTL

Controller for the 8 x 8-bit register file's single write port. After reset it runs an initialisation sequence that writes each register with its own index (r0=0 … r7=7) through the normal write port, replacing any level-sensitive preload. It then shares the write port between two writeback requesters (A, B) using round-robin arbitration with a valid/ready handshake. Its outputs drive the register file's `Write_Reg_Num`, `Write_Data` and `RegWrite` directly.

---
 rtl/regfile_write_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Write-port controller for an 8x8 register file: boots every register to its own
// index, then round-robins the single write port between two valid/ready requesters.
module regfile_write_arbiter #(
    parameter int NUM_REGS = 8,
    parameter int REG_AW   = 3,
    parameter int DW       = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              A_Valid,
    input  logic [REG_AW-1:0] A_Reg,
    input  logic [DW-1:0]     A_Data,
    output logic              A_Ready,
    input  logic              B_Valid,
    input  logic [REG_AW-1:0] B_Reg,
    input  logic [DW-1:0]     B_Data,
    output logic              B_Ready,
    input  logic              Init_Req,
    output logic [REG_AW-1:0] Write_Reg_Num,
    output logic [DW-1:0]     Write_Data,
    output logic              RegWrite,
    output logic              Init_Done
);

    typedef enum logic [1:0] {START, INIT, RUN} state_t;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [DW-1:0]     data;
    } wr_req_t;

    state_t            state, state_nxt;
    logic [REG_AW-1:0] cnt, cnt_nxt;
    logic              last_b, last_b_nxt;
    wr_req_t           held;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state  <= START;
            cnt    <= '0;
            last_b <= 1'b1;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            last_b <= last_b_nxt;
        end
    end

    // Idle cycles replay the last committed address/data so the port does not toggle.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            held <= '0;
        else if (RegWrite)
            held <= '{addr: Write_Reg_Num, data: Write_Data};
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        last_b_nxt    = last_b;
        A_Ready       = 1'b0;
        B_Ready       = 1'b0;
        RegWrite      = 1'b0;
        Init_Done     = 1'b0;
        Write_Reg_Num = held.addr;
        Write_Data    = held.data;
        case (state)
            START: begin
                state_nxt = INIT;
                cnt_nxt   = '0;
            end
            INIT: begin
                RegWrite      = 1'b1;
                Write_Reg_Num = cnt;
                Write_Data    = DW'(cnt);
                cnt_nxt       = cnt + 1'b1;
                if (cnt == REG_AW'(NUM_REGS - 1)) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                Init_Done = 1'b1;
                if (Init_Req) begin
                    state_nxt = INIT;
                    cnt_nxt   = '0;
                end else if (A_Valid && (!B_Valid || last_b)) begin
                    A_Ready       = 1'b1;
                    RegWrite      = 1'b1;
                    Write_Reg_Num = A_Reg;
                    Write_Data    = A_Data;
                    last_b_nxt    = 1'b0;
                end else if (B_Valid) begin
                    B_Ready       = 1'b1;
                    RegWrite      = 1'b1;
                    Write_Reg_Num = B_Reg;
                    Write_Data    = B_Data;
                    last_b_nxt    = 1'b1;
                end
            end
            default: state_nxt = START;
        endcase
    end

endmodule
